clock_phase_gen: RTL and testbench
==================================

// Module: clock_phase_gen
// PURPOSE
//  Parametrised, multi-channel clock-enable/divided-clock generator for the processor skeleton; generalises the fixed /2 and /4 divider chain.
//  Each of NUM_CH channels has a run-time divide ratio and phase offset and emits a registered divided clock plus a one-cycle enable pulse.
//  A RUN/HALT/STEP mode FSM freezes or single-steps all channels at a channel-0 period boundary, for debug of imem/dmem/regfile/processor timing.
// PARAMETERS
//  NUM_CH       4  number of output channels (>=1)
//  DIV_W        4  width of each per-channel divide ratio and phase field
//  DEFAULT_DIV  4  divide ratio loaded into every channel on reset (phase 0)
// PORTS
//  clock      in   1             master clock; all logic on rising edge
//  reset      in   1             synchronous, active-high reset
//  cfg_load   in   1             pulse: capture cfg_div/cfg_phase
//  cfg_div    in   NUM_CH*DIV_W  per-channel divide ratio, ch i at [i*DIV_W +: DIV_W]
//  cfg_phase  in   NUM_CH*DIV_W  per-channel phase offset, same packing
//  cfg_ack    out  1             pulse: new config applied this cycle
//  halt_req   in   1             request halt at next channel-0 period end
//  run_req    in   1             leave HALT, free-run
//  step_req   in   1             from HALT, run exactly one channel-0 period
//  mode       out  2             00 RUN, 01 HALT, 10 STEP
//  clk_out    out  NUM_CH        registered divided clocks
//  ce_out     out  NUM_CH        registered one-cycle enables, coincide with clk_out rising
// BEHAVIOUR
//  Sanitising: div_i==0 treated as 1; phase_i>=div_i treated as 0. hi_i=(div_i+1)>>1.
//  Per-channel counter c_i in 0..div_i-1; init_i = 0 if phase_i==0 else div_i-phase_i.
//  Reset (sync, highest priority): div_i=DEFAULT_DIV, phase_i=0, c_i=init_i, mode=RUN,
//   halt_pend=0, clk_out=0, ce_out=0, cfg_ack=0 while reset sampled high.
//  Running (RUN or STEP), each edge: clk_out_i<=(c_i<hi_i); ce_out_i<=(c_i==0); c_i<=(c_i==div_i-1)?0:c_i+1.
//   => with phase 0, ce_out_i high after edge 0 (first edge with reset low) and every div_i edges;
//      clk_out_i high for hi_i edges, low for div_i-hi_i (odd ratios: high one extra cycle); div 1: clk_out=1, ce every cycle.
//   => phase p delays channel by p cycles: first ce_out_i after edge p.
//  HALT: counters frozen at init_i; clk_out=0, ce_out=0 from the first HALT edge.
//  Config: cfg_load captures fields into shadow regs; on the next edge all c_i reload to new init_i,
//   div/phase take effect, cfg_ack pulses 1 cycle, outputs on that edge computed as in HALT (0);
//   mode unchanged, except STEP restarts a full period. cfg_load while previous apply pending: latest wins.
//  FSM (priority reset > config apply > halt_req > run_req > step_req):
//   RUN: halt_req sets halt_pend; run_req clears halt_pend (halt_req same cycle wins).
//    When halt_pend && c_0==div_0-1: outputs register normally, all c_i reload init_i, mode->HALT, halt_pend=0.
//   HALT: run_req -> RUN next edge; else step_req -> STEP; halt_req ignored.
//   STEP: run div_0 edges starting from init; on edge with c_0==div_0-1 reload all c_i, mode->HALT.
//    halt_req in STEP ignored (step already ends in HALT); run_req in STEP -> continue as RUN, no halt.
//  Channels other than 0 are truncated mid-period at halt; they restart phase-aligned from init_i.
//  No combinational path from any input to any output.
// TESTING
//  Reset then NUM_CH=4, defaults -> every channel: clk_out 1,1,0,0 repeating, ce_out at edges 0,4,8.
//  cfg div={4,3,2,1}, phase={0,1,0,0} -> cfg_ack 1 cycle; ch0 ce at 0,4..; ch1 clk 0,1,1,0,1,1 with ce at 1,4,7; ch3 clk/ce held 1.
//  RUN div0=4, halt_req at c_0=1 -> mode=HALT after edge with c_0=3; clk_out/ce_out 0 thereafter; counters at init.
//  HALT, step_req -> mode=STEP, exactly one ch0 ce pulse and 4 edges of activity, then HALT again.
//  HALT, run_req+step_req same cycle -> RUN; halt_req+run_req in RUN same cycle -> halt_pend set.
//  cfg div=0, phase=7 on div 4 channel, then reset asserted mid-STEP -> div0 behaves as 1/phase 0; reset restores RUN, DEFAULT_DIV.

Source files
------------

// File: rtl/clock_phase_gen.sv
// Multi-channel divided-clock / clock-enable generator with per-channel ratio and phase,
// plus a RUN/HALT/STEP mode machine that freezes or single-steps on channel-0 period ends.
module clock_phase_gen #(
    parameter int NUM_CH      = 4,
    parameter int DIV_W       = 4,
    parameter int DEFAULT_DIV = 4
) (
    input  logic                    clock,
    input  logic                    reset,
    input  logic                    cfg_load,
    input  logic [NUM_CH*DIV_W-1:0] cfg_div,
    input  logic [NUM_CH*DIV_W-1:0] cfg_phase,
    output logic                    cfg_ack,
    input  logic                    halt_req,
    input  logic                    run_req,
    input  logic                    step_req,
    output logic [1:0]              mode,
    output logic [NUM_CH-1:0]       clk_out,
    output logic [NUM_CH-1:0]       ce_out
);

    typedef enum logic [1:0] {
        MODE_RUN  = 2'b00,
        MODE_HALT = 2'b01,
        MODE_STEP = 2'b10
    } mode_t;

    localparam logic [DIV_W-1:0] DEF_DIV = (DEFAULT_DIV == 0) ? DIV_W'(1) : DIV_W'(DEFAULT_DIV);

    function automatic logic [DIV_W-1:0] san_div(input logic [DIV_W-1:0] d);
        return (d == '0) ? DIV_W'(1) : d;
    endfunction

    function automatic logic [DIV_W-1:0] san_phase(input logic [DIV_W-1:0] d, input logic [DIV_W-1:0] p);
        return (p >= d) ? '0 : p;
    endfunction

    function automatic logic [DIV_W-1:0] init_cnt(input logic [DIV_W-1:0] d, input logic [DIV_W-1:0] p);
        return (p == '0) ? '0 : (d - p);
    endfunction

    function automatic logic [DIV_W-1:0] hi_cnt(input logic [DIV_W-1:0] d);
        logic [DIV_W:0] t;
        t = {1'b0, d} + (DIV_W+1)'(1);
        return t[DIV_W:1];
    endfunction

    logic [NUM_CH-1:0][DIV_W-1:0] div_q, div_d, phase_q, phase_d, cnt_q, cnt_d;
    logic [NUM_CH-1:0][DIV_W-1:0] sdiv_q, sdiv_d, sphase_q, sphase_d;
    logic                         apply_q, apply_d;
    logic                         halt_pend_q, halt_pend_d;
    logic                         ack_q, ack_d;
    mode_t                        mode_q, mode_d;
    logic [NUM_CH-1:0]            clk_q, clk_d, ce_q, ce_d;
    logic                         wrap0_s;

    // Next-state logic: config apply, channel counters and mode transitions.
    always_comb begin
        div_d       = div_q;
        phase_d     = phase_q;
        sdiv_d      = sdiv_q;
        sphase_d    = sphase_q;
        cnt_d       = cnt_q;
        mode_d      = mode_q;
        halt_pend_d = halt_pend_q;
        clk_d       = '0;
        ce_d        = '0;
        ack_d       = 1'b0;
        apply_d     = cfg_load;
        wrap0_s     = (cnt_q[0] == (div_q[0] - DIV_W'(1)));

        // Shadow fields are stored already sanitised so the apply edge is a plain copy.
        if (cfg_load) begin
            for (int i = 0; i < NUM_CH; i++) begin
                sdiv_d[i]   = san_div(cfg_div[i*DIV_W +: DIV_W]);
                sphase_d[i] = san_phase(san_div(cfg_div[i*DIV_W +: DIV_W]), cfg_phase[i*DIV_W +: DIV_W]);
            end
        end else begin
            sdiv_d   = sdiv_q;
            sphase_d = sphase_q;
        end

        if (apply_q) begin
            div_d   = sdiv_q;
            phase_d = sphase_q;
            ack_d   = 1'b1;
            for (int i = 0; i < NUM_CH; i++) begin
                cnt_d[i] = init_cnt(sdiv_q[i], sphase_q[i]);
            end
        end else begin
            if (mode_q != MODE_HALT) begin
                for (int i = 0; i < NUM_CH; i++) begin
                    clk_d[i] = (cnt_q[i] < hi_cnt(div_q[i]));
                    ce_d[i]  = (cnt_q[i] == '0);
                    cnt_d[i] = (cnt_q[i] == (div_q[i] - DIV_W'(1))) ? '0 : (cnt_q[i] + DIV_W'(1));
                end
            end else begin
                cnt_d = cnt_q;
            end

            case (mode_q)
                MODE_RUN: begin
                    if (halt_req) begin
                        halt_pend_d = 1'b1;
                    end else if (run_req) begin
                        halt_pend_d = 1'b0;
                    end else begin
                        halt_pend_d = halt_pend_q;
                    end
                    if (halt_pend_q && wrap0_s) begin
                        mode_d      = MODE_HALT;
                        halt_pend_d = 1'b0;
                        for (int i = 0; i < NUM_CH; i++) begin
                            cnt_d[i] = init_cnt(div_q[i], phase_q[i]);
                        end
                    end else begin
                        mode_d = MODE_RUN;
                    end
                end
                MODE_HALT: begin
                    if (run_req) begin
                        mode_d = MODE_RUN;
                    end else if (step_req) begin
                        mode_d = MODE_STEP;
                    end else begin
                        mode_d = MODE_HALT;
                    end
                end
                MODE_STEP: begin
                    if (run_req) begin
                        mode_d = MODE_RUN;
                    end else if (wrap0_s) begin
                        mode_d = MODE_HALT;
                        for (int i = 0; i < NUM_CH; i++) begin
                            cnt_d[i] = init_cnt(div_q[i], phase_q[i]);
                        end
                    end else begin
                        mode_d = MODE_STEP;
                    end
                end
                default: begin
                    mode_d      = MODE_RUN;
                    halt_pend_d = 1'b0;
                end
            endcase
        end
    end

    // State registers with synchronous reset.
    always_ff @(posedge clock) begin
        if (reset) begin
            for (int i = 0; i < NUM_CH; i++) begin
                div_q[i]    <= DEF_DIV;
                phase_q[i]  <= '0;
                sdiv_q[i]   <= DEF_DIV;
                sphase_q[i] <= '0;
                cnt_q[i]    <= '0;
            end
            apply_q     <= 1'b0;
            halt_pend_q <= 1'b0;
            ack_q       <= 1'b0;
            mode_q      <= MODE_RUN;
            clk_q       <= '0;
            ce_q        <= '0;
        end else begin
            div_q       <= div_d;
            phase_q     <= phase_d;
            sdiv_q      <= sdiv_d;
            sphase_q    <= sphase_d;
            cnt_q       <= cnt_d;
            apply_q     <= apply_d;
            halt_pend_q <= halt_pend_d;
            ack_q       <= ack_d;
            mode_q      <= mode_d;
            clk_q       <= clk_d;
            ce_q        <= ce_d;
        end
    end

    assign cfg_ack = ack_q;
    assign mode    = mode_q;
    assign clk_out = clk_q;
    assign ce_out  = ce_q;

endmodule

// File: tb/tb_clock_phase_gen.sv
// Directed bench for clock_phase_gen: stimulus pushes hand-computed expected outputs
// into a queue; a negedge monitor pops and compares one entry per clock.
module tb_clock_phase_gen;
    localparam logic [1:0] M_RUN  = 2'b00;
    localparam logic [1:0] M_HALT = 2'b01;
    localparam logic [1:0] M_STEP = 2'b10;

    logic        clock = 1'b0;
    logic        reset, cfg_load, halt_req, run_req, step_req;
    logic [15:0] cfg_div, cfg_phase;
    logic        cfg_ack;
    logic [1:0]  mode;
    logic [3:0]  clk_out, ce_out;

    logic [10:0] exp_q[$];
    logic [10:0] mon_exp, mon_act;
    int          n_cmp = 0;
    int          n_err = 0;
    int          n_cyc = 0;

    always #5 clock = ~clock;

    clock_phase_gen #(.NUM_CH(4), .DIV_W(4), .DEFAULT_DIV(4)) dut (
        .clock    (clock),
        .reset    (reset),
        .cfg_load (cfg_load),
        .cfg_div  (cfg_div),
        .cfg_phase(cfg_phase),
        .cfg_ack  (cfg_ack),
        .halt_req (halt_req),
        .run_req  (run_req),
        .step_req (step_req),
        .mode     (mode),
        .clk_out  (clk_out),
        .ce_out   (ce_out)
    );

    // Queue the response expected after the coming edge, clock it, release request pulses.
    task automatic ex(input logic [1:0] m, input logic ack, input logic [3:0] ck, input logic [3:0] ce);
        exp_q.push_back({m, ack, ck, ce});
        @(posedge clock);
        #1;
        cfg_load = 1'b0;
        halt_req = 1'b0;
        run_req  = 1'b0;
        step_req = 1'b0;
    endtask

    // Monitor: one comparison per clock whenever an expectation is queued.
    always @(negedge clock) begin
        n_cyc++;
        if (exp_q.size() > 0) begin
            mon_exp = exp_q.pop_front();
            mon_act = {mode, cfg_ack, clk_out, ce_out};
            n_cmp++;
            if (mon_act !== mon_exp) begin
                n_err++;
                $display("FAIL outputs@cyc%0d: got mode=%b ack=%b clk=%b ce=%b, want mode=%b ack=%b clk=%b ce=%b",
                         n_cyc, mon_act[10:9], mon_act[8], mon_act[7:4], mon_act[3:0],
                         mon_exp[10:9], mon_exp[8], mon_exp[7:4], mon_exp[3:0]);
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout, want completion");
        $fatal(1);
    end

    initial begin
        reset = 1'b1; cfg_load = 1'b0; halt_req = 1'b0; run_req = 1'b0; step_req = 1'b0;
        cfg_div = {4{4'd4}}; cfg_phase = 16'h0000;
        ex(M_RUN, 1'b0, 4'h0, 4'h0);
        ex(M_RUN, 1'b0, 4'h0, 4'h0);
        reset = 1'b0;

        // defaults: every channel /4, clk 1,1,0,0, ce at 0,4,8
        for (int k = 0; k < 2; k++) begin
            ex(M_RUN, 1'b0, 4'hF, 4'hF);
            ex(M_RUN, 1'b0, 4'hF, 4'h0);
            ex(M_RUN, 1'b0, 4'h0, 4'h0);
            ex(M_RUN, 1'b0, 4'h0, 4'h0);
        end
        ex(M_RUN, 1'b0, 4'hF, 4'hF);

        // div {4,3,2,1}, phase {0,1,0,0}
        cfg_div = {4'd1, 4'd2, 4'd3, 4'd4}; cfg_phase = {4'd0, 4'd0, 4'd1, 4'd0}; cfg_load = 1'b1;
        ex(M_RUN, 1'b0, 4'hF, 4'h0);
        ex(M_RUN, 1'b1, 4'h0, 4'h0);
        ex(M_RUN, 1'b0, 4'hD, 4'hD);
        ex(M_RUN, 1'b0, 4'hB, 4'hA);
        ex(M_RUN, 1'b0, 4'hE, 4'hC);
        ex(M_RUN, 1'b0, 4'h8, 4'h8);
        ex(M_RUN, 1'b0, 4'hF, 4'hF);
        ex(M_RUN, 1'b0, 4'hB, 4'h8);
        ex(M_RUN, 1'b0, 4'hC, 4'hC);
        ex(M_RUN, 1'b0, 4'hA, 4'hA);
        ex(M_RUN, 1'b0, 4'hF, 4'hD);

        // halt request at c_0=1, halt takes effect on the c_0=3 edge
        halt_req = 1'b1;
        ex(M_RUN, 1'b0, 4'h9, 4'h8);
        ex(M_RUN, 1'b0, 4'hE, 4'hE);
        ex(M_HALT, 1'b0, 4'hA, 4'h8);
        ex(M_HALT, 1'b0, 4'h0, 4'h0);
        halt_req = 1'b1;
        ex(M_HALT, 1'b0, 4'h0, 4'h0);
        ex(M_HALT, 1'b0, 4'h0, 4'h0);

        // single step: one ch0 period from init, then back to HALT
        step_req = 1'b1;
        ex(M_STEP, 1'b0, 4'h0, 4'h0);
        ex(M_STEP, 1'b0, 4'hD, 4'hD);
        ex(M_STEP, 1'b0, 4'hB, 4'hA);
        ex(M_STEP, 1'b0, 4'hE, 4'hC);
        ex(M_HALT, 1'b0, 4'h8, 4'h8);
        ex(M_HALT, 1'b0, 4'h0, 4'h0);
        ex(M_HALT, 1'b0, 4'h0, 4'h0);

        // run beats step; halt beats run in RUN
        run_req = 1'b1; step_req = 1'b1;
        ex(M_RUN, 1'b0, 4'h0, 4'h0);
        ex(M_RUN, 1'b0, 4'hD, 4'hD);
        ex(M_RUN, 1'b0, 4'hB, 4'hA);
        halt_req = 1'b1; run_req = 1'b1;
        ex(M_RUN, 1'b0, 4'hE, 4'hC);
        ex(M_HALT, 1'b0, 4'h8, 4'h8);
        ex(M_HALT, 1'b0, 4'h0, 4'h0);

        // ch0 div 0 -> 1, phase 7 -> 0; applied while halted
        cfg_div = {4'd1, 4'd2, 4'd3, 4'd0}; cfg_phase = {4'd0, 4'd0, 4'd1, 4'd7}; cfg_load = 1'b1;
        ex(M_HALT, 1'b0, 4'h0, 4'h0);
        ex(M_HALT, 1'b1, 4'h0, 4'h0);
        ex(M_HALT, 1'b0, 4'h0, 4'h0);
        run_req = 1'b1;
        ex(M_RUN, 1'b0, 4'h0, 4'h0);
        ex(M_RUN, 1'b0, 4'hD, 4'hD);
        ex(M_RUN, 1'b0, 4'hB, 4'hB);
        ex(M_RUN, 1'b0, 4'hF, 4'hD);
        halt_req = 1'b1;
        ex(M_RUN, 1'b0, 4'h9, 4'h9);
        ex(M_HALT, 1'b0, 4'hF, 4'hF);

        // reset in the middle of STEP restores RUN and /4 defaults
        step_req = 1'b1;
        ex(M_STEP, 1'b0, 4'h0, 4'h0);
        reset = 1'b1;
        ex(M_RUN, 1'b0, 4'h0, 4'h0);
        ex(M_RUN, 1'b0, 4'h0, 4'h0);
        reset = 1'b0;
        ex(M_RUN, 1'b0, 4'hF, 4'hF);
        ex(M_RUN, 1'b0, 4'hF, 4'h0);
        ex(M_RUN, 1'b0, 4'h0, 4'h0);
        ex(M_RUN, 1'b0, 4'h0, 4'h0);
        ex(M_RUN, 1'b0, 4'hF, 4'hF);

        @(negedge clock);
        #1;
        n_cmp++;
        if (exp_q.size() != 0) begin
            n_err++;
            $display("FAIL drain: got %0d pending, want 0", exp_q.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
